// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the system-bus to register-bus bridge:
// default geometry and the bridge FSM state encoding.
package bus_bridge_pkg;

  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STRB = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/bus_tmo_cnt.sv
// Saturating ack-timeout counter. 'expired' fires on the enabled cycle in
// which the TMO_CYC-th cycle since the clear is reached.
module bus_tmo_cnt
  import bus_bridge_pkg::*;
#(
  parameter int TMO_CYC = TMO_DEF
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TMO_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare before the increment lands so the response leaves on time.
  assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/bus_reg_bridge.sv
// Bridges a single-outstanding system-bus request to a strobe/ack register
// bus, with an ack timeout and a one-cycle response pulse upstream.
module bus_reg_bridge
  import bus_bridge_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TMO_CYC = TMO_DEF
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [AW-1:0]   sys_addr_i,
  input  logic [DW-1:0]   sys_wdata_i,
  input  logic [DW/8-1:0] sys_sel_i,
  input  logic            sys_wen_i,
  input  logic            sys_ren_i,
  output logic [DW-1:0]   sys_rdata_o,
  output logic            sys_err_o,
  output logic            sys_ack_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] sel_o,
  output logic            wen_o,
  output logic            ren_o,
  input  logic [DW-1:0]   rdata_i,
  input  logic            err_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic [1:0]      state_o
);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            wen_q, wen_d, ren_q, ren_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d, ack_q, ack_d, busy_q, busy_d;
  logic            tmo_expired;

  // Response registers default to zero so they are only non-zero with ack.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sys_wen_i ^ sys_ren_i) begin
          addr_d  = sys_addr_i;
          wdata_d = sys_wdata_i;
          sel_d   = sys_sel_i;
          wen_d   = sys_wen_i;
          ren_d   = sys_ren_i;
          state_d = ST_STRB;
        end else if (sys_wen_i && sys_ren_i) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_STRB, ST_WAIT: begin
        if (ack_i || err_i) begin
          rdata_d = rdata_i;
          err_d   = err_i;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  bus_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr     (state_q == ST_STRB),
    .en      (state_q == ST_WAIT),
    .expired (tmo_expired)
  );

  assign sys_rdata_o = rdata_q;
  assign sys_err_o   = err_q;
  assign sys_ack_o   = ack_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign sel_o       = sel_q;
  assign wen_o       = wen_q;
  assign ren_o       = ren_q;
  assign busy_o      = busy_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bus_reg_bridge.sv
// Directed bench for bus_reg_bridge (TMO_CYC=4). Handshake: a request is
// sampled on a rising edge in IDLE; the response is a one-cycle sys_ack_o.
module tb_bus_reg_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 49;  // {cycle[15:0], err, rdata[31:0]}

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [AW-1:0]   sys_addr = '0;
  logic [DW-1:0]   sys_wdata = '0;
  logic [DW/8-1:0] sys_sel = '0;
  logic            sys_wen = 1'b0, sys_ren = 1'b0;
  logic [DW-1:0]   sys_rdata;
  logic            sys_err, sys_ack;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            wen, ren;
  logic [DW-1:0]   rdata = '0;
  logic            err = 1'b0, ack = 1'b0;
  logic            busy;
  logic [1:0]      state;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int tests = 0, failed = 0;
  int ack_cnt = 0, wen_cnt = 0, ren_cnt = 0;
  int t0, n_wen, n_ren, n_ack;

  bus_reg_bridge #(.AW(AW), .DW(DW), .TMO_CYC(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack),
    .addr_o(addr), .wdata_o(wdata), .sel_o(sel), .wen_o(wen), .ren_o(ren),
    .rdata_i(rdata), .err_i(err), .ack_i(ack),
    .busy_o(busy), .state_o(state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_req(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    sys_wen = w; sys_ren = r; sys_addr = a; sys_wdata = d; sys_sel = s;
  endtask

  task automatic clear_req();
    sys_wen = 1'b0; sys_ren = 1'b0;
  endtask

  task automatic push_exp(input int at_cyc, input logic e, input logic [31:0] d);
    exp_q.push_back({16'(at_cyc), e, d});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (sys_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {15'd0, sys_err, sys_rdata}, 64'h1_0000_0000_0000);
        end else begin
          chk("resp", {cyc[15:0], sys_err, sys_rdata}, exp_q.pop_front());
        end
      end else begin
        chk("resp_zero_when_idle", {sys_err, sys_rdata}, 64'd0);
      end
      if (wen) wen_cnt++;
      if (ren) ren_cnt++;
    end
  end

  initial begin
    // reset state
    step(2);
    chk("rst_ack_busy", {sys_ack, busy, wen, ren, state}, 64'd0);
    chk("rst_regs", {addr, wdata, sel}, 64'd0);
    chk("rst_resp", {sys_err, sys_rdata}, 64'd0);

    // write, released with reset: ack_i two cycles after the strobe
    rstn = 1'b1;
    t0 = cyc;
    drive_req(1, 0, 32'h40, 32'hDEADBEEF, 4'hF);
    push_exp(t0 + 4, 1'b0, 32'h0);
    step(1);
    clear_req();
    chk("wr_strobe", {wen, ren, busy}, 64'b101);
    chk("wr_addr", addr, 64'h40);
    chk("wr_data_sel", {wdata, sel}, {28'd0, 32'hDEADBEEF, 4'hF});
    step(1);
    chk("wr_strobe_one_cycle", wen, 64'd0);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    chk("wr_done", {busy, state}, 64'd0);
    chk("wr_single_strobe", wen_cnt, 64'd1);

    // read, ack_i together with ren_o
    t0 = cyc;
    drive_req(0, 1, 32'h80, 32'h0, 4'hF);
    push_exp(t0 + 2, 1'b0, 32'h12345678);
    step(1);
    clear_req();
    chk("rd_strobe", {wen, ren}, 64'b01);
    ack = 1'b1; rdata = 32'h12345678;
    step(1);
    ack = 1'b0; rdata = 32'h0;
    step(1);
    chk("rd_done", busy, 64'd0);

    // timeout: no ack, rdata_i noise must not leak into the response
    n_ren = ren_cnt; n_ack = ack_cnt;
    t0 = cyc;
    drive_req(0, 1, 32'h100, 32'h0, 4'h3);
    push_exp(t0 + 6, 1'b1, 32'h0);
    rdata = 32'hAAAA5555;
    step(1);
    clear_req();
    step(4);
    chk("tmo_busy_c5", busy, 64'd1);
    step(2);
    chk("tmo_idle_c7", busy, 64'd0);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0; rdata = 32'h0;
    step(2);
    chk("tmo_late_ack_ignored", ack_cnt - n_ack, 64'd1);
    chk("tmo_one_strobe", ren_cnt - n_ren, 64'd1);
    chk("tmo_addr_held", {addr, sel}, {28'd0, 32'h100, 4'h3});

    // illegal: wen and ren together
    n_wen = wen_cnt; n_ren = ren_cnt;
    t0 = cyc;
    drive_req(1, 1, 32'h1234, 32'h5555, 4'h1);
    push_exp(t0 + 1, 1'b1, 32'h0);
    step(1);
    clear_req();
    chk("ill_no_strobe", {wen, ren}, 64'd0);
    step(2);
    chk("ill_no_strobe_cnt", (wen_cnt - n_wen) + (ren_cnt - n_ren), 64'd0);
    chk("ill_addr_unchanged", addr, 64'h100);

    // busy drop: second write while busy is ignored
    n_wen = wen_cnt; n_ack = ack_cnt;
    t0 = cyc;
    drive_req(1, 0, 32'h200, 32'h11112222, 4'hC);
    push_exp(t0 + 5, 1'b0, 32'h0);
    step(1);
    clear_req();
    step(1);
    drive_req(1, 0, 32'h300, 32'h33334444, 4'h3);
    step(2);
    clear_req();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(3);
    chk("busy_one_strobe", wen_cnt - n_wen, 64'd1);
    chk("busy_one_ack", ack_cnt - n_ack, 64'd1);
    chk("busy_addr_first", {addr, wdata}, {32'h200, 32'h11112222});

    // downstream error response
    t0 = cyc;
    drive_req(1, 0, 32'h44, 32'h9, 4'h1);
    push_exp(t0 + 3, 1'b1, 32'h0);
    step(1);
    clear_req();
    step(1);
    err = 1'b1;
    step(1);
    err = 1'b0;
    step(2);

    // reset in WAIT aborts without a response
    n_ack = ack_cnt;
    drive_req(0, 1, 32'h500, 32'h0, 4'hF);
    step(1);
    clear_req();
    step(2);
    chk("pre_rst_in_wait", state, 64'd2);
    rstn = 1'b0;
    #1;
    chk("rst_wait_outputs", {sys_ack, busy, wen, ren, state, sys_err}, 64'd0);
    chk("rst_wait_regs", {addr, sel, sys_rdata}, 64'd0);
    step(2);
    rstn = 1'b1;
    step(3);
    chk("rst_no_ack", ack_cnt - n_ack, 64'd0);

    // next request after reset completes normally
    t0 = cyc;
    drive_req(0, 1, 32'h600, 32'h0, 4'hF);
    push_exp(t0 + 3, 1'b0, 32'hCAFEF00D);
    step(1);
    clear_req();
    chk("post_rst_strobe", {ren, addr}, {1'b1, 32'h600});
    step(1);
    ack = 1'b1; rdata = 32'hCAFEF00D;
    step(1);
    ack = 1'b0; rdata = 32'h0;
    step(3);
    chk("scoreboard_drained", exp_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
